// File: rtl/mux_pkg.sv
// Sizing helpers shared by the pipelined word multiplexer.
// A tree of N 2:1 levels is cut into register stages of LVL_PER_STG levels each;
// these functions give stage count, levels per stage and per-stage data/sel widths.
package mux_pkg;

  // Number of register stages; a zero-level tree still gets one slice.
  function automatic int unsigned n_stages(int unsigned n, int unsigned lps);
    return (n == 0) ? 1 : (n + lps - 1) / lps;
  endfunction

  // Tree levels completed before stage s starts.
  function automatic int unsigned lvls_done(int unsigned s, int unsigned n, int unsigned lps);
    int unsigned d = s * lps;
    return (d > n) ? n : d;
  endfunction

  // Tree levels evaluated inside stage s; the last stage may hold fewer.
  function automatic int unsigned lvls_in_stage(int unsigned s, int unsigned n,
                                                int unsigned lps);
    return lvls_done(s + 1, n, lps) - lvls_done(s, n, lps);
  endfunction

  // Select port width; a single-word tree still has a 1-bit (ignored) select.
  function automatic int unsigned sel_w(int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  // Data register width of stage s.
  function automatic int unsigned stage_data_w(int unsigned s, int unsigned n,
                                               int unsigned lps, int unsigned width);
    return width << (n - lvls_done(s + 1, n, lps));
  endfunction

endpackage

// File: rtl/mux_n_pipe_if.sv
// Handshake bundle of mux_n_pipe.
//   in_data/in_sel/in_valid/in_ready : upstream beat (2**N words of WIDTH bits + word index)
//   out_data/out_valid/out_ready     : downstream selected word
// slave  = the multiplexer, master = whoever drives and consumes it.
interface mux_n_pipe_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned SelW = mux_pkg::sel_w(N);

  logic [(WIDTH << N)-1:0] in_data;
  logic [SelW-1:0]         in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mux2.sv
// 2:1 mux cell, WIDTH bits wide.
//   a0_i/a1_i : candidate words, sel_i : picks a1_i when 1, y_o : result
module mux2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = sel_i ? a1_i : a0_i;
endmodule

// File: rtl/mux_lvl.sv
// One combinational tree level: pairs words 2k/2k+1 and steers each pair with sel_i.
//   data_i : WORDS words, data_o : WORDS/2 words, sel_i : level select bit
module mux_lvl #(
  parameter int unsigned WORDS = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic [WORDS*WIDTH-1:0]     data_i,
  input  logic                       sel_i,
  output logic [(WORDS/2)*WIDTH-1:0] data_o
);
  for (genvar k = 0; k < WORDS / 2; k++) begin : g_pair
    mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .a0_i (data_i[(2*k)*WIDTH +: WIDTH]),
      .a1_i (data_i[(2*k+1)*WIDTH +: WIDTH]),
      .sel_i(sel_i),
      .y_o  (data_o[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: rtl/mux_n_pipe.sv
// Pipelined WIDTH-bit, 2**N-input word multiplexer with valid/ready handshake.
// A 2:1 tree (LSB select bit at level 0) is sliced into register stages of LVL_PER_STG levels;
// every beat carries its unconsumed select bits alongside its partially reduced data.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux_n_pipe_if (in_* beat, out_* selected word)
module mux_n_pipe import mux_pkg::*; #(
  parameter int unsigned N           = 3,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LVL_PER_STG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_n_pipe_if.slave  bus
);
  localparam int unsigned Stages = n_stages(N, LVL_PER_STG);
  localparam int unsigned SelW   = sel_w(N);
  localparam int unsigned FullW  = WIDTH << N;

  // Stage outputs, zero-extended to the widest data so they fit one array.
  logic [FullW-1:0]  stg_data [Stages];
  logic [SelW-1:0]   stg_sel  [Stages];
  logic [Stages-1:0] stg_valid;
  // rdy[s]: stage s can take a beat this cycle. Pure combinational chain from out_ready.
  logic [Stages:0]   rdy;

  assign rdy[Stages]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar s = 0; s < Stages; s++) begin : g_stage
    localparam int unsigned Lv   = lvls_in_stage(s, N, LVL_PER_STG);
    localparam int unsigned InW  = WIDTH << (N - lvls_done(s, N, LVL_PER_STG));
    localparam int unsigned OutW = stage_data_w(s, N, LVL_PER_STG, WIDTH);

    logic [Lv:0][InW-1:0] lvl;
    logic [SelW-1:0]      sel_in;
    logic                 valid_in;
    logic [OutW-1:0]      data_q;
    logic [SelW-1:0]      sel_q;
    logic                 valid_q;
    logic                 load;
    logic                 unused_lvl;

    if (s == 0) begin : g_src_port
      assign lvl[0]   = bus.in_data;
      assign sel_in   = bus.in_sel;
      assign valid_in = bus.in_valid;
    end else begin : g_src_stage
      logic unused_hi;
      assign lvl[0]    = stg_data[s-1][InW-1:0];
      assign sel_in    = stg_sel[s-1];
      assign valid_in  = stg_valid[s-1];
      assign unused_hi = ^stg_data[s-1][FullW-1:InW];
    end

    // Remaining select bits sit at the LSB end, so level l of this stage uses sel_in[l].
    for (genvar l = 0; l < Lv; l++) begin : g_lvl
      localparam int unsigned Words = (InW / WIDTH) >> l;
      logic [(Words/2)*WIDTH-1:0] lvl_out;
      mux_lvl #(
        .WORDS(Words),
        .WIDTH(WIDTH)
      ) u_mux_lvl (
        .data_i(lvl[l][Words*WIDTH-1:0]),
        .sel_i (sel_in[l]),
        .data_o(lvl_out)
      );
      assign lvl[l+1] = InW'(lvl_out);
    end

    // Padding above each level's live words is zero and only reaches this sink.
    assign unused_lvl = ^{lvl, sel_in};

    assign load   = !valid_q || rdy[s+1];
    assign rdy[s] = load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        sel_q   <= '0;
      end else if (load) begin
        valid_q <= valid_in;
        // Payload only moves with a valid beat, so idle garbage never lands in a register.
        if (valid_in) begin
          data_q <= lvl[Lv][OutW-1:0];
          sel_q  <= sel_in >> Lv;
        end
      end
    end

    if (s < Stages - 1) begin : g_fwd
      assign stg_data[s]  = FullW'(data_q);
      assign stg_sel[s]   = sel_q;
      assign stg_valid[s] = valid_q;
    end else begin : g_out
      logic unused_last;
      // Last slot feeds the port directly; its array entries are never consumed.
      assign stg_data[s]   = '0;
      assign stg_sel[s]    = '0;
      assign stg_valid[s]  = 1'b0;
      assign bus.out_data  = data_q;
      assign bus.out_valid = valid_q;
      assign unused_last   = ^{sel_q, stg_data[s], stg_sel[s], stg_valid[s]};
    end
  end
endmodule

// File: tb/tb_mux_n_pipe.sv
module tb_mux_n_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // a: N=3 W=8 L=1 (3 stages)   b: N=0 W=4 (1 stage)
  // c: N=5 W=8 L=2 (3 stages)   d: N=4 W=16 L=3 (2 stages)
  mux_n_pipe_if #(.N(3), .WIDTH(8))  if_a ();
  mux_n_pipe_if #(.N(0), .WIDTH(4))  if_b ();
  mux_n_pipe_if #(.N(5), .WIDTH(8))  if_c ();
  mux_n_pipe_if #(.N(4), .WIDTH(16)) if_d ();

  mux_n_pipe #(.N(3), .WIDTH(8),  .LVL_PER_STG(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  mux_n_pipe #(.N(0), .WIDTH(4),  .LVL_PER_STG(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  mux_n_pipe #(.N(5), .WIDTH(8),  .LVL_PER_STG(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  mux_n_pipe #(.N(4), .WIDTH(16), .LVL_PER_STG(3)) u_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  logic [7:0]  qa[$];
  logic [15:0] qd[$];
  logic [7:0]  last_a;

  assert property (@(posedge clk) disable iff (!rst_n)
                   (if_d.out_valid && !if_d.out_ready) |=> $stable(if_d.out_data))
    else begin
      fails++;
      $display("FAIL assert_hold_d: out_data changed while stalled, now %h", if_d.out_data);
    end

  task automatic idle_all();
    if_a.in_valid = 0; if_a.in_data = '0; if_a.in_sel = '0; if_a.out_ready = 0;
    if_b.in_valid = 0; if_b.in_data = '0; if_b.in_sel = '0; if_b.out_ready = 0;
    if_c.in_valid = 0; if_c.in_data = '0; if_c.in_sel = '0; if_c.out_ready = 0;
    if_d.in_valid = 0; if_d.in_data = '0; if_d.in_sel = '0; if_d.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({if_a.out_valid, if_b.out_valid, if_c.out_valid, if_d.out_valid} !== 4'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b%b%b%b want 0000", if_a.out_valid, if_b.out_valid,
               if_c.out_valid, if_d.out_valid);
    end
    tests++;
    if (if_a.out_data !== 8'h0 || if_d.out_data !== 16'h0 || if_c.out_data !== 8'h0) begin
      fails++;
      $display("FAIL reset_data: got a=%h c=%h d=%h want 0", if_a.out_data, if_c.out_data,
               if_d.out_data);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    tests++;
    if ({if_a.in_ready, if_b.in_ready, if_c.in_ready, if_d.in_ready} !== 4'b1111) begin
      fails++;
      $display("FAIL reset_ready: got %b%b%b%b want 1111", if_a.in_ready, if_b.in_ready,
               if_c.in_ready, if_d.in_ready);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp;
    int first_out = -1;
    int got = 0;
    int acc = 0;
    bit gap = 0;
    idle_all();
    for (int k = 0; k < 8; k++) if_a.in_data[k*8 +: 8] = 8'h10 + 8'(k);
    if_a.out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if_a.in_valid = (i < 8);
      if_a.in_sel   = 3'(i);
      #1;
      if (if_a.out_valid) begin
        if (first_out < 0) first_out = i;
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        got++;
        tests++;
        if (if_a.out_data !== exp) begin
          fails++;
          $display("FAIL stream_data: got %h want %h", if_a.out_data, exp);
        end
        last_a = if_a.out_data;
      end else if (first_out >= 0 && got < 8) begin
        gap = 1;
      end
      if (if_a.in_valid && if_a.in_ready) begin
        qa.push_back(8'h10 + 8'(i));
        acc++;
      end
    end
    if_a.in_valid = 0;
    tests++;
    if (first_out != 3) begin
      fails++;
      $display("FAIL stream_latency: first out at cycle %0d want 3", first_out);
    end
    tests++;
    if (got != 8 || acc != 8 || gap) begin
      fails++;
      $display("FAIL stream_count: got %0d out %0d in gap=%0d want 8 8 0", got, acc, gap);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held = '0;
    logic [7:0] exp;
    logic [63:0] dd;
    bit held_v = 0;
    int popped = 0;
    int s;
    idle_all();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dd = {$urandom(), $urandom()};
      s = $urandom_range(7);
      if_a.in_valid = 1; if_a.in_data = dd; if_a.in_sel = 3'(s); if_a.out_ready = 0;
      #1;
      tests++;
      if (if_a.in_ready !== (qa.size() < 3)) begin
        fails++;
        $display("FAIL bp_ready cyc %0d: got %b want %b", i, if_a.in_ready, qa.size() < 3);
      end
      if (if_a.out_valid) begin
        tests++;
        if (if_a.out_data !== qa[0] || (held_v && if_a.out_data !== held)) begin
          fails++;
          $display("FAIL bp_hold cyc %0d: got %h want %h", i, if_a.out_data, qa[0]);
        end
        held = if_a.out_data; held_v = 1;
      end
      if (if_a.in_valid && if_a.in_ready) qa.push_back(dd[s*8 +: 8]);
    end
    tests++;
    if (qa.size() != 3 || !held_v) begin
      fails++;
      $display("FAIL bp_fill: got %0d beats held=%0d want 3 1", qa.size(), held_v);
    end
    // Full pipe, out_ready=1: input and output both fire in the same cycle.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dd = {$urandom(), $urandom()};
      s = $urandom_range(7);
      if_a.in_valid = (i < 2); if_a.in_data = dd; if_a.in_sel = 3'(s); if_a.out_ready = 1;
      #1;
      if (i < 2) begin
        tests++;
        if (if_a.in_ready !== 1'b1) begin
          fails++;
          $display("FAIL bp_full_ready cyc %0d: got %b want 1", i, if_a.in_ready);
        end
      end
      if (if_a.out_valid) begin
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        popped++;
        tests++;
        if (if_a.out_data !== exp) begin
          fails++;
          $display("FAIL bp_order: got %h want %h", if_a.out_data, exp);
        end
        last_a = if_a.out_data;
      end
      if (if_a.in_valid && if_a.in_ready) qa.push_back(dd[s*8 +: 8]);
    end
    tests++;
    if (popped != 5 || qa.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d out %0d left want 5 0", popped, qa.size());
    end
  endtask

  task automatic test_bubble();
    bit vpat [7] = '{1, 0, 1, 0, 0, 1, 1};
    logic [7:0] exp;
    logic [7:0] w;
    int first = -1;
    int last = -1;
    int popped = 0;
    idle_all();
    for (int k = 0; k < 8; k++) if_a.in_data[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if_a.in_valid = vpat[i];
      if_a.in_sel   = 3'(i);
      w = 8'hA0 + 8'(i);
      #1;
      tests++;
      if (if_a.in_ready !== (qa.size() < 3)) begin
        fails++;
        $display("FAIL bubble_ready cyc %0d: got %b want %b", i, if_a.in_ready, qa.size() < 3);
      end
      if (if_a.in_valid && if_a.in_ready) qa.push_back(w);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_a.in_valid = 0; if_a.out_ready = 1;
      #1;
      if (if_a.out_valid) begin
        if (first < 0) first = i;
        last = i;
        exp = (qa.size() > 0) ? qa.pop_front() : 8'hxx;
        popped++;
        tests++;
        if (if_a.out_data !== exp) begin
          fails++;
          $display("FAIL bubble_order: got %h want %h", if_a.out_data, exp);
        end
        last_a = if_a.out_data;
      end
    end
    tests++;
    if (popped != 3 || last - first != 2) begin
      fails++;
      $display("FAIL bubble_pack: got %0d beats over %0d cycles want 3 over 2", popped,
               last - first);
    end
  endtask

  task automatic test_garbage();
    idle_all();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_a.in_valid = 0; if_a.in_sel = 'x; if_a.in_data = 'x; if_a.out_ready = i[0];
      #1;
      tests++;
      if (if_a.out_valid !== 1'b0 || if_a.out_data !== last_a) begin
        fails++;
        $display("FAIL garbage_idle cyc %0d: got v=%b d=%h want v=0 d=%h", i, if_a.out_valid,
                 if_a.out_data, last_a);
      end
    end
    idle_all();
  endtask

  task automatic test_midrun_reset();
    idle_all();
    for (int k = 0; k < 8; k++) if_a.in_data[k*8 +: 8] = 8'h30 + 8'(k);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_a.in_valid = (i < 3); if_a.in_sel = 3'(i + 1);
    end
    #1;
    tests++;
    if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'h31) begin
      fails++;
      $display("FAIL midrst_pre: got v=%b d=%h want v=1 d=31", if_a.out_valid, if_a.out_data);
    end
    #1;
    rst_n = 0;
    #1;
    tests++;
    if (if_a.out_valid !== 1'b0 || if_a.out_data !== 8'h0) begin
      fails++;
      $display("FAIL midrst_async: got v=%b d=%h want v=0 d=00", if_a.out_valid,
               if_a.out_data);
    end
    idle_all();
    qa.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    tests++;
    if (if_a.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_ready: got %b want 1", if_a.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_a.out_ready = 1;
      #1;
      tests++;
      if (if_a.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst_ghost cyc %0d: got out_valid %b want 0", i, if_a.out_valid);
      end
    end
    idle_all();
  endtask

  task automatic test_n0();
    bit exp_v [3] = '{0, 1, 0};
    idle_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_b.out_ready = 1;
      if_b.in_valid  = (i == 0);
      if_b.in_data   = (i == 0) ? 4'hA : 4'h3;
      if_b.in_sel    = 1'(i);
      #1;
      tests++;
      if (if_b.out_valid !== exp_v[i] || (exp_v[i] && if_b.out_data !== 4'hA)) begin
        fails++;
        $display("FAIL n0 cyc %0d: got v=%b d=%h want v=%b d=a", i, if_b.out_valid,
                 if_b.out_data, exp_v[i]);
      end
    end
  endtask

  task automatic test_wide();
    logic [255:0] dd;
    logic [7:0] exp [6];
    bit exp_v [6] = '{0, 0, 0, 1, 1, 0};
    idle_all();
    for (int k = 0; k < 8; k++) dd[k*32 +: 32] = $urandom();
    exp[3] = dd[31*8 +: 8];
    exp[4] = dd[7*8 +: 8];
    if_c.in_data = dd;
    if_c.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if_c.in_valid = (i < 2);
      if_c.in_sel   = (i == 0) ? 5'd31 : 5'd7;
      #1;
      tests++;
      if (if_c.out_valid !== exp_v[i] || (exp_v[i] && if_c.out_data !== exp[i])) begin
        fails++;
        $display("FAIL wide cyc %0d: got v=%b d=%h want v=%b d=%h", i, if_c.out_valid,
                 if_c.out_data, exp_v[i], exp[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_random();
    logic [255:0] dd;
    logic [15:0] held = '0;
    logic [15:0] exp;
    bit held_v = 0;
    int acc = 0;
    int cyc = 0;
    int s;
    idle_all();
    while (acc < 10000 && cyc < 40000) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) dd[k*32 +: 32] = $urandom();
      s = $urandom_range(15);
      if_d.in_valid  = ($urandom_range(3) != 0);
      if_d.in_data   = dd;
      if_d.in_sel    = 4'(s);
      if_d.out_ready = ($urandom_range(3) != 0);
      #1;
      tests++;
      if (if_d.in_ready !== ((qd.size() < 2) || if_d.out_ready)) begin
        fails++;
        $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, if_d.in_ready,
                 (qd.size() < 2) || if_d.out_ready);
      end
      if (held_v) begin
        tests++;
        if (if_d.out_valid !== 1'b1 || if_d.out_data !== held) begin
          fails++;
          $display("FAIL rand_hold cyc %0d: got v=%b d=%h want v=1 d=%h", cyc, if_d.out_valid,
                   if_d.out_data, held);
        end
      end
      held_v = 0;
      if (if_d.out_valid) begin
        if (if_d.out_ready) begin
          exp = (qd.size() > 0) ? qd.pop_front() : 16'hxxxx;
          tests++;
          if (if_d.out_data !== exp) begin
            fails++;
            $display("FAIL rand_data cyc %0d: got %h want %h", cyc, if_d.out_data, exp);
          end
        end else begin
          held_v = 1;
          held = if_d.out_data;
        end
      end
      if (if_d.in_valid && if_d.in_ready) begin
        qd.push_back(dd[s*16 +: 16]);
        acc++;
      end
      cyc++;
    end
    tests++;
    if (acc != 10000) begin
      fails++;
      $display("FAIL rand_budget: got %0d beats in %0d cycles want 10000", acc, cyc);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_d.in_valid = 0; if_d.out_ready = 1;
      #1;
      if (if_d.out_valid) begin
        exp = (qd.size() > 0) ? qd.pop_front() : 16'hxxxx;
        tests++;
        if (if_d.out_data !== exp) begin
          fails++;
          $display("FAIL rand_drain: got %h want %h", if_d.out_data, exp);
        end
      end
    end
    tests++;
    if (qd.size() != 0) begin
      fails++;
      $display("FAIL rand_left: got %0d beats stuck want 0", qd.size());
    end
  endtask

  initial begin
    last_a = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_garbage();
    test_midrun_reset();
    test_n0();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
